mode_tracker: RTL and testbench

//  Line-following decision FSM. Produces the 5-bit mode/last_mode command that the motor driver consumes.

---
 rtl/car_mode_pkg.sv | 60 ++++++
 rtl/mode_tracker_if.sv | 17 +
 rtl/sensor_filter.sv | 39 +++
 rtl/mode_tracker.sv | 165 ++++++++++++++++
 tb/tb_mode_tracker.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/car_mode_pkg.sv
// Shared mode command codes and route direction codes for the line-following car.
// Latency: none (types and pure functions only).
// Backpressure: none.
package car_mode_pkg;

    // 5-bit command codes; the motor driver decodes these same values.
    typedef enum logic [4:0] {
        MODE_IDLE         = 5'd0,
        MODE_START        = 5'd1,
        MODE_COUNT        = 5'd2,
        MODE_STRAIGHT     = 5'd3,
        MODE_CHOOSE       = 5'd4,
        MODE_LEFT         = 5'd5,
        MODE_RIGHT        = 5'd6,
        MODE_BACK         = 5'd7,
        MODE_LITTLE_LEFT  = 5'd8,
        MODE_LITTLE_RIGHT = 5'd9,
        MODE_FINISH       = 5'd29,
        MODE_STOP         = 5'd30,
        MODE_ERROR        = 5'd31
    } mode_t;

    // Direction taken at an intersection, as packed into the route table.
    typedef enum logic [1:0] {
        DIR_STRAIGHT = 2'b00,
        DIR_LEFT     = 2'b01,
        DIR_RIGHT    = 2'b10,
        DIR_BACK     = 2'b11
    } dir_t;

    // Counter width for a count of n cycles; never below one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_tracking(input mode_t m);
        return (m == MODE_STRAIGHT) || (m == MODE_LITTLE_LEFT) || (m == MODE_LITTLE_RIGHT);
    endfunction

    function automatic logic is_turning(input mode_t m);
        return (m == MODE_LEFT) || (m == MODE_RIGHT) || (m == MODE_BACK);
    endfunction

    // States where the car is parked: stop does not apply and busy is low.
    function automatic logic is_parked(input mode_t m);
        return (m == MODE_IDLE) || (m == MODE_FINISH) || (m == MODE_ERROR);
    endfunction

    function automatic mode_t dir_to_mode(input dir_t d);
        mode_t m;
        case (d)
            DIR_LEFT:  m = MODE_LEFT;
            DIR_RIGHT: m = MODE_RIGHT;
            DIR_BACK:  m = MODE_BACK;
            default:   m = MODE_STRAIGHT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mode_tracker_if.sv
// Bundle between sensor front-end/controls and the mode tracker: inputs start/stop/sensor, outputs mode/last_mode/step/busy.
// Latency: wires only.
// Backpressure: none; master drives start/stop/sensor, slave (the tracker) drives the command outputs.
interface mode_tracker_if;
    import car_mode_pkg::*;

    logic        start;      // one-cycle pulse
    logic        stop;       // level
    logic [2:0]  sensor;     // {L,M,R}, 1 = black line
    mode_t       mode;       // current command
    mode_t       last_mode;  // command before the most recent change
    logic [3:0]  step;       // next route entry index
    logic        busy;       // mode not IDLE/FINISH/ERROR

    modport master (output start, stop, sensor, input mode, last_mode, step, busy);
    modport slave  (input start, stop, sensor, output mode, last_mode, step, busy);
endinterface

// File: rtl/sensor_filter.sv
// Per-bit stability filter: filt[b] takes raw[b] once raw[b] has differed from filt[b] for FILT_CYCLES consecutive edges.
// Latency: FILT_CYCLES clocks from a stable raw change to filt.
// Backpressure: none. Ports: clk, rst (async high), raw[WIDTH], filt[WIDTH].
module sensor_filter #(
    parameter int WIDTH       = 3,
    parameter int FILT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] filt
);
    import car_mode_pkg::*;

    localparam int FW = cnt_w(FILT_CYCLES);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [FW-1:0] cnt;
        logic          f;

        // Any cycle where raw agrees with the filtered value restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                f   <= 1'b0;
            end else if (raw[b] == f) begin
                cnt <= '0;
            end else if (cnt == FW'(FILT_CYCLES - 1)) begin
                f   <= raw[b];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign filt[b] = f;
    end

endmodule

// File: rtl/mode_tracker.sv
// Line-following decision FSM producing the mode/last_mode command for the motor driver.
// Latency: every transition lands on the clk edge after its cause; sensor adds FILT_CYCLES of filtering.
// Backpressure: none. Ports: clk, rst (async high), bus (slave: start, stop, sensor in; mode, last_mode, step, busy out).
// Optional build macro TRACKER_LOST_RECOVERY_EN: first lost-line event backs up and retries instead of erroring.
module mode_tracker #(
    parameter int                    FILT_CYCLES     = 1000,
    parameter int                    COUNT_CYCLES    = 300_000_000,
    parameter int                    TURN_MIN_CYCLES = 20_000_000,
    parameter int                    TURN_MAX_CYCLES = 200_000_000,
    parameter int                    LOST_CYCLES     = 50_000_000,
    parameter int                    ROUTE_LEN       = 8,
    parameter logic [2*ROUTE_LEN-1:0] ROUTE          = '0
) (
    input  logic          clk,
    input  logic          rst,
    mode_tracker_if.slave bus
);
    import car_mode_pkg::*;

    localparam int CW = cnt_w(COUNT_CYCLES);
    localparam int TW = cnt_w(TURN_MAX_CYCLES);
    localparam int LW = cnt_w(LOST_CYCLES);

    logic [2:0]    sensor_f;
    mode_t         mode_q, last_q, mode_nxt;
    logic          busy_q;
    logic [3:0]    step_q;
    logic [CW-1:0] count_cnt;
    logic [TW-1:0] turn_cnt;
    logic [LW-1:0] lost_cnt;
    logic          lost_evt;
    logic          recover_q;   // current BACK is a lost-line recovery, not a routed turn
    dir_t          route_tab [16];

    sensor_filter #(.WIDTH(3), .FILT_CYCLES(FILT_CYCLES)) u_filt (
        .clk  (clk),
        .rst  (rst),
        .raw  (bus.sensor),
        .filt (sensor_f)
    );

    // Unpack the route so it can be indexed directly by the 4-bit step.
    for (genvar g = 0; g < 16; g++) begin : g_route
        if (g < ROUTE_LEN) begin : g_used
            assign route_tab[g] = dir_t'(ROUTE[2*g +: 2]);
        end else begin : g_unused
            assign route_tab[g] = DIR_STRAIGHT;
        end
    end

`ifdef TRACKER_LOST_RECOVERY_EN
    logic retry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recover_q <= 1'b0;
            retry_q   <= 1'b0;
        end else if (is_tracking(mode_q) && mode_nxt == MODE_BACK) begin
            recover_q <= 1'b1;
            retry_q   <= 1'b1;
        end else begin
            if (mode_nxt != MODE_BACK)
                recover_q <= 1'b0;
            if (mode_nxt == MODE_CHOOSE || mode_nxt == MODE_IDLE)
                retry_q <= 1'b0;
        end
    end
`else
    assign recover_q = 1'b0;
`endif

    always_comb begin
        mode_nxt = mode_q;
        lost_evt = (sensor_f == 3'b000) && (lost_cnt == LW'(LOST_CYCLES - 1));
        case (mode_q)
            MODE_IDLE:  if (bus.start && !bus.stop) mode_nxt = MODE_START;
            MODE_START: mode_nxt = MODE_COUNT;
            MODE_COUNT: if (count_cnt == CW'(COUNT_CYCLES - 1)) mode_nxt = MODE_STRAIGHT;
            MODE_STRAIGHT, MODE_LITTLE_LEFT, MODE_LITTLE_RIGHT: begin
                case (sensor_f)
                    3'b010, 3'b101: mode_nxt = MODE_STRAIGHT;
                    3'b100, 3'b110: mode_nxt = MODE_LITTLE_LEFT;
                    3'b001, 3'b011: mode_nxt = MODE_LITTLE_RIGHT;
                    3'b111:         mode_nxt = MODE_CHOOSE;
                    default: begin
                        // All white: hold the steering and let the lost timer run.
                        if (lost_evt) begin
`ifdef TRACKER_LOST_RECOVERY_EN
                            mode_nxt = retry_q ? MODE_ERROR : MODE_BACK;
`else
                            mode_nxt = MODE_ERROR;
`endif
                        end
                    end
                endcase
            end
            MODE_CHOOSE: begin
                if (step_q == 4'(ROUTE_LEN))
                    mode_nxt = MODE_FINISH;
                else if (sensor_f != 3'b111)
                    mode_nxt = dir_to_mode(route_tab[step_q]);
            end
            MODE_LEFT, MODE_RIGHT, MODE_BACK: begin
                // Timeout wins over a re-acquire seen on the same cycle.
                if (turn_cnt == TW'(TURN_MAX_CYCLES - 1))
                    mode_nxt = MODE_ERROR;
                else if (turn_cnt >= TW'(TURN_MIN_CYCLES - 1) && (sensor_f == 3'b010 || recover_q))
                    mode_nxt = MODE_STRAIGHT;
            end
            MODE_STOP:   if (!bus.stop) mode_nxt = MODE_STRAIGHT;
            MODE_FINISH,
            MODE_ERROR:  if (bus.start && !bus.stop) mode_nxt = MODE_IDLE;
            default:     mode_nxt = MODE_IDLE;
        endcase
        if (bus.stop && !is_parked(mode_q))
            mode_nxt = MODE_STOP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_IDLE;
            last_q    <= MODE_IDLE;
            busy_q    <= 1'b0;
            step_q    <= '0;
            count_cnt <= '0;
            turn_cnt  <= '0;
            lost_cnt  <= '0;
        end else begin
            mode_q <= mode_nxt;
            if (mode_nxt != mode_q)
                last_q <= mode_q;
            busy_q <= !is_parked(mode_nxt);

            // Timers run only while staying in their state, so entry always starts them at zero
            // and STOP clears them.
            if (mode_q == MODE_COUNT && mode_nxt == MODE_COUNT)
                count_cnt <= (count_cnt == '1) ? count_cnt : count_cnt + 1'b1;
            else
                count_cnt <= '0;

            if (is_turning(mode_q) && mode_nxt == mode_q)
                turn_cnt <= (turn_cnt == '1) ? turn_cnt : turn_cnt + 1'b1;
            else
                turn_cnt <= '0;

            if (is_tracking(mode_q) && is_tracking(mode_nxt) && sensor_f == 3'b000)
                lost_cnt <= (lost_cnt == '1) ? lost_cnt : lost_cnt + 1'b1;
            else
                lost_cnt <= '0;

            if (mode_q == MODE_CHOOSE && (mode_nxt == MODE_STRAIGHT || is_turning(mode_nxt))) begin
                if (step_q != 4'(ROUTE_LEN))
                    step_q <= step_q + 1'b1;
            end else if ((mode_q == MODE_FINISH || mode_q == MODE_ERROR) && mode_nxt == MODE_IDLE) begin
                step_q <= '0;
            end
        end
    end

    assign bus.mode      = mode_q;
    assign bus.last_mode = last_q;
    assign bus.step      = step_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mode_tracker.sv
// Directed bench for mode_tracker: vector table for the main route run, hand sequences for lost line, stop, turn timeout, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_mode_tracker;
    import car_mode_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mode_tracker_if bus();

    mode_tracker #(
        .FILT_CYCLES     (4),
        .COUNT_CYCLES    (10),
        .TURN_MIN_CYCLES (8),
        .TURN_MAX_CYCLES (50),
        .LOST_CYCLES     (20),
        .ROUTE_LEN       (2),
        .ROUTE           (4'b10_01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic [2:0] sensor;
        logic [7:0] cycles;
        logic [4:0] mode;
        logic [4:0] last;
        logic [3:0] step;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    // Apply inputs on a falling edge, then let n rising edges pass; sampling happens on the falling edge.
    task automatic drive(input logic st, input logic sp, input logic [2:0] s, input int n);
        bus.start  = st;
        bus.stop   = sp;
        bus.sensor = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [4:0] m, input logic [4:0] lm, input logic [3:0] st);
        logic eb;
        eb = !(m == 5'd0 || m == 5'd29 || m == 5'd31);
        n_vec++;
        if (bus.mode !== m || bus.last_mode !== lm || bus.step !== st || bus.busy !== eb) begin
            n_bad++;
            $display("FAIL %s: got mode=%0d last=%0d step=%0d busy=%0d, want mode=%0d last=%0d step=%0d busy=%0d",
                     name, bus.mode, bus.last_mode, bus.step, bus.busy, m, lm, st, eb);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.sensor = 3'b010;
        repeat (2) @(negedge clk);
        check("reset", 5'd0, 5'd0, 4'd0);
        rst = 1'b0;

        //            st    sp    sensor   cyc   mode   last   step
        vecs[0]  = '{1'b0, 1'b0, 3'b010, 8'd6, 5'd0,  5'd0,  4'd0};  // idle, filter settles
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 8'd1, 5'd1,  5'd0,  4'd0};  // start -> START
        vecs[2]  = '{1'b0, 1'b0, 3'b010, 8'd1, 5'd2,  5'd1,  4'd0};  // -> COUNT
        vecs[3]  = '{1'b0, 1'b0, 3'b010, 8'd9, 5'd2,  5'd1,  4'd0};  // 9 cycles into COUNT
        vecs[4]  = '{1'b0, 1'b0, 3'b010, 8'd1, 5'd3,  5'd2,  4'd0};  // 10th -> STRAIGHT
        vecs[5]  = '{1'b0, 1'b0, 3'b110, 8'd4, 5'd3,  5'd2,  4'd0};  // filtering
        vecs[6]  = '{1'b0, 1'b0, 3'b110, 8'd1, 5'd8,  5'd3,  4'd0};  // LITTLE_LEFT
        vecs[7]  = '{1'b0, 1'b0, 3'b001, 8'd2, 5'd8,  5'd3,  4'd0};  // glitch
        vecs[8]  = '{1'b0, 1'b0, 3'b110, 8'd6, 5'd8,  5'd3,  4'd0};  // glitch rejected
        vecs[9]  = '{1'b0, 1'b0, 3'b111, 8'd4, 5'd8,  5'd3,  4'd0};
        vecs[10] = '{1'b0, 1'b0, 3'b111, 8'd1, 5'd4,  5'd8,  4'd0};  // CHOOSE
        vecs[11] = '{1'b0, 1'b0, 3'b000, 8'd4, 5'd4,  5'd8,  4'd0};  // still 111 filtered
        vecs[12] = '{1'b0, 1'b0, 3'b000, 8'd1, 5'd5,  5'd4,  4'd1};  // route[0] LEFT
        vecs[13] = '{1'b0, 1'b0, 3'b000, 8'd1, 5'd5,  5'd4,  4'd1};
        vecs[14] = '{1'b0, 1'b0, 3'b010, 8'd6, 5'd5,  5'd4,  4'd1};  // 010 seen early, ignored
        vecs[15] = '{1'b0, 1'b0, 3'b010, 8'd1, 5'd3,  5'd5,  4'd1};  // 8th turn cycle -> STRAIGHT
        vecs[16] = '{1'b0, 1'b0, 3'b111, 8'd5, 5'd4,  5'd3,  4'd1};  // CHOOSE
        vecs[17] = '{1'b0, 1'b0, 3'b010, 8'd5, 5'd6,  5'd4,  4'd2};  // route[1] RIGHT
        vecs[18] = '{1'b0, 1'b0, 3'b010, 8'd7, 5'd6,  5'd4,  4'd2};
        vecs[19] = '{1'b0, 1'b0, 3'b010, 8'd1, 5'd3,  5'd6,  4'd2};
        vecs[20] = '{1'b0, 1'b0, 3'b111, 8'd5, 5'd4,  5'd3,  4'd2};  // route exhausted
        vecs[21] = '{1'b0, 1'b0, 3'b111, 8'd1, 5'd29, 5'd4,  4'd2};  // FINISH
        vecs[22] = '{1'b0, 1'b0, 3'b111, 8'd3, 5'd29, 5'd4,  4'd2};
        vecs[23] = '{1'b1, 1'b0, 3'b111, 8'd1, 5'd0,  5'd29, 4'd0};  // start -> IDLE, step cleared
        vecs[24] = '{1'b0, 1'b0, 3'b010, 8'd1, 5'd0,  5'd29, 4'd0};

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].sensor, int'(vecs[i].cycles));
            check($sformatf("vec%0d", i), vecs[i].mode, vecs[i].last, vecs[i].step);
        end

        // Lost line while tracking.
        drive(1'b0, 1'b0, 3'b010, 6);
        drive(1'b1, 1'b0, 3'b010, 1);
        drive(1'b0, 1'b0, 3'b010, 11);
        check("lost_track", 5'd3, 5'd2, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 23);
        check("lost_before", 5'd3, 5'd2, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 1);
`ifdef TRACKER_LOST_RECOVERY_EN
        check("lost_back", 5'd7, 5'd3, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 7);
        check("lost_back_hold", 5'd7, 5'd3, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 1);
        check("lost_retry", 5'd3, 5'd7, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 19);
        check("lost2_before", 5'd3, 5'd7, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 1);
        check("lost2_error", 5'd31, 5'd3, 4'd0);
`else
        check("lost_error", 5'd31, 5'd3, 4'd0);
`endif
        drive(1'b1, 1'b0, 3'b000, 1);
        check("error_exit", 5'd0, 5'd31, 4'd0);

        // Stop during a turn; start together with stop is ignored.
        drive(1'b0, 1'b0, 3'b010, 6);
        drive(1'b1, 1'b0, 3'b010, 1);
        drive(1'b0, 1'b0, 3'b010, 11);
        check("stop_track", 5'd3, 5'd2, 4'd0);
        drive(1'b0, 1'b0, 3'b111, 5);
        check("stop_choose", 5'd4, 5'd3, 4'd0);
        drive(1'b0, 1'b0, 3'b000, 5);
        check("stop_left", 5'd5, 5'd4, 4'd1);
        drive(1'b1, 1'b1, 3'b000, 1);
        check("stop_enter", 5'd30, 5'd5, 4'd1);
        drive(1'b0, 1'b1, 3'b000, 3);
        check("stop_hold", 5'd30, 5'd5, 4'd1);
        drive(1'b0, 1'b0, 3'b000, 1);
        check("stop_release", 5'd3, 5'd30, 4'd1);

        // Turn that never re-acquires hits the timeout.
        drive(1'b0, 1'b0, 3'b111, 5);
        check("tmax_choose", 5'd4, 5'd3, 4'd1);
        drive(1'b0, 1'b0, 3'b000, 5);
        check("tmax_right", 5'd6, 5'd4, 4'd2);
        drive(1'b0, 1'b0, 3'b000, 49);
        check("tmax_before", 5'd6, 5'd4, 4'd2);
        drive(1'b0, 1'b0, 3'b000, 1);
        check("tmax_error", 5'd31, 5'd6, 4'd2);
        drive(1'b1, 1'b0, 3'b000, 1);
        check("tmax_exit", 5'd0, 5'd31, 4'd0);

        // Asynchronous reset in the middle of a turn.
        drive(1'b0, 1'b0, 3'b010, 6);
        drive(1'b1, 1'b0, 3'b010, 1);
        drive(1'b0, 1'b0, 3'b010, 11);
        drive(1'b0, 1'b0, 3'b111, 5);
        drive(1'b0, 1'b0, 3'b000, 5);
        check("rst_left", 5'd5, 5'd4, 4'd1);
        drive(1'b0, 1'b0, 3'b000, 2);
        #2 rst = 1'b1;
        #1 check("rst_async", 5'd0, 5'd0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 2);
        check("rst_after", 5'd0, 5'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
